stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 800000, meaning tick period in clk cycles minus one (period = TICK_DIV+1).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 65536, meaning consecutive stable synchronized samples required to accept a button level change.
REQ-003 SHALL have parameter LAP_HOLD_TICKS, default 20 (5-bit), meaning ticks a captured lap value stays on the display.
REQ-004 clk  input  1  system clock; all flops on posedge clk.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 btn_start_stop  input  1  active-high raw button, asynchronous to clk.
REQ-007 btn_lap  input  1  active-high raw button, asynchronous to clk.
REQ-008 btn_clear  input  1  active-high raw button, asynchronous to clk.
REQ-009 display_value  output  8  two BCD digits for the seven-segment controller, [7:4] tens, [3:0] units.
REQ-010 running  output  1  high in state RUN.
REQ-011 lap_active  output  1  high while display_value shows the lap capture.
REQ-012 tick  output  1  registered one-cycle pulse per elapsed tick period in RUN.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive identical synchronized samples differing from it.
REQ-014 A one-cycle press pulse SHALL be generated on each debounced 0->1 transition; releases and held levels SHALL generate nothing.
REQ-015 FSM states IDLE, RUN, STOP; reset state IDLE.
REQ-016 IDLE: start_stop press -> RUN, tick divider cleared to 0; lap and clear presses ignored.
REQ-017 RUN: start_stop press -> STOP; clear press ignored.
REQ-018 STOP: start_stop press -> RUN, divider resumes from its held value; clear press -> IDLE with counter = 8'h00 and lap state cleared.
REQ-019 Divider SHALL count only in RUN, hold in STOP, and wrap 0..TICK_DIV; tick SHALL be high for one cycle when the divider equals TICK_DIV.
REQ-020 On each clock edge where tick is high, the counter SHALL advance by BCD increment: units 9 -> 0 with tens carry; 8'h99 -> 8'h00 (wrap, no flag).
REQ-021 Counter digits SHALL never hold values A-F.
REQ-022 RUN lap press: lap_value <= current counter; lap_timer <= LAP_HOLD_TICKS; lap_active <= 1; a lap press while lap_active SHALL recapture and reload.
REQ-023 While lap_active, lap_timer SHALL decrement on each tick; lap_active SHALL drop on the edge where lap_timer goes 1 -> 0; counter keeps advancing throughout.
REQ-024 STOP lap press SHALL clear lap_active immediately (show live value).
REQ-025 display_value SHALL be lap_value when lap_active, else counter; registered, updated the cycle after the source changes.
REQ-026 Simultaneous press pulses: start_stop SHALL take priority; lap and clear in that cycle SHALL be discarded.
REQ-027 Entering STOP SHALL hold lap_timer (lap display freezes with the stopwatch).

Reset
REQ-028 nrst low SHALL immediately force: state IDLE, counter 8'h00, lap_value 8'h00, lap_timer 0, divider 0, synchronizers/debouncers to released (0), display_value 8'h00, running 0, lap_active 0, tick 0.
REQ-029 Reset assertion mid-operation SHALL abandon any count or lap without a partial update; release SHALL require a fresh start_stop press.

Structure
REQ-030 Package stopwatch_pkg SHALL hold the state encoding (IDLE, RUN, STOP), BCD_WIDTH = 8, and the 8'h99 wrap constant.
REQ-031 One sub-module btn_debounce (synchronizer + debouncer + press pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated three times; BCD increment reuses the existing bcd8_increment.

Verification (TICK_DIV=9, DEBOUNCE_CYCLES=4, LAP_HOLD_TICKS=3)
REQ-032 Reset, press start_stop, run 25 ticks -> display_value 8'h25, running 1, tick period exactly 10 clk.
REQ-033 Run from 8'h98 for 2 ticks -> 8'h99 then 8'h00, no A-F digit at any cycle.
REQ-034 Lap press at counter 8'h12 -> display holds 8'h12 for 3 ticks, lap_active drops, display 8'h15.
REQ-035 2-cycle glitches on each button, 4-cycle pulse on start_stop -> glitches produce no change; pulse enters RUN.
REQ-036 Clear in RUN -> ignored; stop at 8'h07, clear -> IDLE, 8'h00; start_stop+clear same cycle in STOP -> RUN, count retained.
REQ-037 nrst low mid-RUN at 8'h42 with lap_active -> all outputs 0 within the same cycle, asynchronously, state IDLE after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Stopwatch shared definitions.
// State encoding, BCD constants and the BCD increment helper.
`timescale 1ns/1ps
package stopwatch_pkg;

    localparam int BCD_WIDTH = 8;
    localparam logic [BCD_WIDTH-1:0] BCD_WRAP = 8'h99;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } sw_state_t;

    // Two-digit BCD +1; 99 rolls over to 00.
    function automatic logic [BCD_WIDTH-1:0] bcd8_increment(
        input logic [BCD_WIDTH-1:0] v
    );
        logic [3:0] units;
        logic [3:0] tens;
        units = v[3:0];
        tens  = v[7:4];
        if (v >= BCD_WRAP) begin
            return 8'h00;
        end
        if (units >= 4'd9) begin
            return {tens + 4'd1, 4'd0};
        end
        return {tens, units + 4'd1};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, debouncer,
// and a one-cycle pulse on each accepted press.
`timescale 1ns/1ps
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn,
    output logic press
);

    localparam int CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after an unbroken run of samples.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            level_q <= level;
            if (sync2 != level) begin
                if (cnt == CNT_MAX) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop/lap/clear FSM,
// tick divider, BCD seconds counter and lap display hold.
`timescale 1ns/1ps
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = 800000,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int LAP_HOLD_TICKS  = 20
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic [7:0] display_value,
    output logic       running,
    output logic       lap_active,
    output logic       tick
);

    localparam int DW =
        (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam logic [DW-1:0] DIV_MAX  = DW'(TICK_DIV);
    localparam logic [4:0]    LAP_LOAD = 5'(LAP_HOLD_TICKS);

    sw_state_t            state;
    sw_state_t            state_n;
    logic                 ss_p;
    logic                 lap_p;
    logic                 clr_p;
    logic [DW-1:0]        div;
    logic [BCD_WIDTH-1:0] counter;
    logic [BCD_WIDTH-1:0] lap_value;
    logic [4:0]           lap_timer;
    logic                 lap_act;
    logic                 clr_evt;
    logic                 lap_cap;
    logic                 lap_kill;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk   (clk),
        .nrst  (nrst),
        .btn   (btn_start_stop),
        .press (ss_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk   (clk),
        .nrst  (nrst),
        .btn   (btn_lap),
        .press (lap_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk   (clk),
        .nrst  (nrst),
        .btn   (btn_clear),
        .press (clr_p)
    );

    // start_stop wins; lap/clear in the same cycle are dropped.
    assign clr_evt  = (state == STOP) && clr_p && !ss_p;
    assign lap_cap  = (state == RUN) && lap_p && !ss_p;
    assign lap_kill = (state == STOP) && lap_p && !ss_p;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode from the press pulses.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (ss_p) state_n = RUN;
            RUN:  if (ss_p) state_n = STOP;
            STOP: begin
                if (ss_p) begin
                    state_n = RUN;
                end else if (clr_p) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Tick divider: runs in RUN, freezes in STOP.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div    <= '0;
            tick   <= 1'b0;
        end else begin
            tick <= (state == RUN) && (div == DIV_MAX);
            if ((state == IDLE) && ss_p) begin
                div <= '0;
            end else if (state == RUN) begin
                div <= (div == DIV_MAX) ? '0 : div + 1'b1;
            end else if (clr_evt) begin
                div <= '0;
            end
        end
    end

    // BCD elapsed-time counter.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            counter <= '0;
        end else if (clr_evt) begin
            counter <= '0;
        end else if (tick) begin
            counter <= bcd8_increment(counter);
        end
    end

    // Lap capture and hold timer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lap_value <= '0;
            lap_timer <= '0;
            lap_act   <= 1'b0;
        end else if (clr_evt) begin
            lap_value <= '0;
            lap_timer <= '0;
            lap_act   <= 1'b0;
        end else if (lap_cap) begin
            lap_value <= counter;
            lap_timer <= LAP_LOAD;
            lap_act   <= 1'b1;
        end else if (lap_kill) begin
            lap_act <= 1'b0;
        end else if (lap_act && tick) begin
            lap_timer <= lap_timer - 1'b1;
            if (lap_timer == 5'd1) begin
                lap_act <= 1'b0;
            end
        end
    end

    // Registered display source select.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            display_value <= '0;
        end else begin
            display_value <= lap_act ? lap_value : counter;
        end
    end

    assign running    = (state == RUN);
    assign lap_active = lap_act;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl.
// TICK_DIV=9, DEBOUNCE_CYCLES=4, LAP_HOLD_TICKS=3.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       nrst;
    logic       bss;
    logic       blap;
    logic       bclr;
    logic [7:0] disp;
    logic       running;
    logic       lap_active;
    logic       tick;

    int passed = 0;
    int failed = 0;
    int total = 0;
    int cyc = 0;
    int bad_digit = 0;
    int bad_period = 0;
    int last_period = 0;
    int prev_tick = -1;
    bit meas = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (nrst === 1'b1 &&
            (disp[3:0] > 4'd9 || disp[7:4] > 4'd9)) begin
            bad_digit++;
        end
    end

    stopwatch_ctrl #(
        .TICK_DIV        (9),
        .DEBOUNCE_CYCLES (4),
        .LAP_HOLD_TICKS  (3)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .btn_start_stop (bss),
        .btn_lap        (blap),
        .btn_clear      (bclr),
        .display_value  (disp),
        .running        (running),
        .lap_active     (lap_active),
        .tick           (tick)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h",
                   tag, got, exp);
        end
    endtask

    task automatic cwait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit s, input bit l,
                         input bit c, input int len);
        bss  = s;
        blap = l;
        bclr = c;
        cwait(len);
        bss  = 1'b0;
        blap = 1'b0;
        bclr = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (tick !== 1'b1 && k < 40);
            if (tick !== 1'b1) begin
                chk("tick_timeout", {31'd0, tick}, 32'd1);
                return;
            end
            if (meas) begin
                if (prev_tick >= 0) begin
                    last_period = cyc - prev_tick;
                    if (last_period != 10) bad_period++;
                end
                prev_tick = cyc;
            end
        end
    endtask

    initial begin
        nrst = 1'b0;
        bss  = 1'b0;
        blap = 1'b0;
        bclr = 1'b0;
        cwait(3);
        chk("rst_disp", {24'd0, disp}, 32'h00);
        chk("rst_run", {31'd0, running}, 32'd0);
        chk("rst_lap", {31'd0, lap_active}, 32'd0);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        nrst = 1'b1;
        cwait(2);

        // Short glitches must be rejected.
        press(1'b1, 1'b0, 1'b0, 2);
        cwait(8);
        press(1'b0, 1'b1, 1'b0, 2);
        cwait(8);
        press(1'b0, 1'b0, 1'b1, 2);
        cwait(10);
        chk("glitch_run", {31'd0, running}, 32'd0);
        chk("glitch_disp", {24'd0, disp}, 32'h00);
        chk("glitch_lap", {31'd0, lap_active}, 32'd0);

        // Four-cycle press starts the watch.
        meas = 1'b1;
        press(1'b1, 1'b0, 1'b0, 4);
        cwait(4);
        chk("start_run", {31'd0, running}, 32'd1);

        // Lap capture at 12.
        wait_ticks(12);
        press(1'b0, 1'b1, 1'b0, 4);
        cwait(4);
        chk("lap_on", {31'd0, lap_active}, 32'd1);
        chk("lap_disp", {24'd0, disp}, 32'h12);
        wait_ticks(2);
        chk("lap_hold", {24'd0, disp}, 32'h12);
        chk("lap_hold_on", {31'd0, lap_active}, 32'd1);
        wait_ticks(1);
        cwait(2);
        chk("lap_off", {31'd0, lap_active}, 32'd0);
        chk("lap_live", {24'd0, disp}, 32'h15);

        // Reach 25 ticks total.
        wait_ticks(10);
        cwait(2);
        chk("cnt25", {24'd0, disp}, 32'h25);
        chk("run25", {31'd0, running}, 32'd1);
        chk("period_bad", bad_period, 0);
        chk("period_last", last_period, 10);
        meas = 1'b0;

        // BCD roll-over 98 -> 99 -> 00.
        wait_ticks(73);
        cwait(2);
        chk("cnt98", {24'd0, disp}, 32'h98);
        wait_ticks(1);
        cwait(2);
        chk("cnt99", {24'd0, disp}, 32'h99);
        wait_ticks(1);
        cwait(2);
        chk("cnt00", {24'd0, disp}, 32'h00);
        chk("bcd_digits", bad_digit, 0);

        // Clear in RUN is ignored.
        press(1'b0, 1'b0, 1'b1, 4);
        cwait(3);
        chk("clr_run_ign", {31'd0, running}, 32'd1);
        chk("clr_run_cnt", {24'd0, disp}, 32'h00);

        // Stop at 07, hold, then clear.
        wait_ticks(7);
        press(1'b1, 1'b0, 1'b0, 4);
        cwait(4);
        chk("stop_run", {31'd0, running}, 32'd0);
        chk("stop_cnt", {24'd0, disp}, 32'h07);
        cwait(20);
        chk("stop_hold", {24'd0, disp}, 32'h07);
        press(1'b0, 1'b0, 1'b1, 4);
        cwait(4);
        chk("clr_run", {31'd0, running}, 32'd0);
        chk("clr_cnt", {24'd0, disp}, 32'h00);

        // Restart, stop at 03, start+clear together.
        press(1'b1, 1'b0, 1'b0, 4);
        cwait(4);
        chk("restart", {31'd0, running}, 32'd1);
        wait_ticks(3);
        press(1'b1, 1'b0, 1'b0, 4);
        cwait(4);
        chk("stop2", {31'd0, running}, 32'd0);
        cwait(10);
        press(1'b1, 1'b0, 1'b1, 4);
        cwait(3);
        chk("prio_run", {31'd0, running}, 32'd1);
        chk("prio_cnt", {24'd0, disp}, 32'h03);

        // Async reset mid-RUN at 42 with lap shown.
        wait_ticks(39);
        press(1'b0, 1'b1, 1'b0, 4);
        cwait(4);
        chk("lap42_on", {31'd0, lap_active}, 32'd1);
        chk("lap42_disp", {24'd0, disp}, 32'h42);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_disp", {24'd0, disp}, 32'h00);
        chk("arst_run", {31'd0, running}, 32'd0);
        chk("arst_lap", {31'd0, lap_active}, 32'd0);
        chk("arst_tick", {31'd0, tick}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        cwait(30);
        chk("post_idle", {31'd0, running}, 32'd0);
        chk("post_disp", {24'd0, disp}, 32'h00);
        chk("post_tick", {31'd0, tick}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
